// File: rtl/wide_comparator_sequencer.sv
// Byte-serial wide magnitude comparator: latches two NBYTES-byte operands and
// walks them MSB byte first through a single shared 8-bit comparator.

module eight_bit_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       lt_in,
  input  logic       eq_in,
  input  logic       gt_in,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  always_comb begin
    lt = lt_in;
    eq = eq_in;
    gt = gt_in;
    if (a < b) begin
      lt = 1'b1;
      eq = 1'b0;
      gt = 1'b0;
    end else if (a > b) begin
      lt = 1'b0;
      eq = 1'b0;
      gt = 1'b1;
    end
  end

endmodule

module wide_comparator_sequencer #(
  parameter int NBYTES = 4,
  parameter int CW     = $clog2(NBYTES + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                signed_cmp,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                busy,
  output logic                done,
  output logic                lt,
  output logic                eq,
  output logic                gt,
  output logic [CW-1:0]       ncmp
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NBYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sgn_q, sgn_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lt_q, lt_d;
  logic          eq_q, eq_d;
  logic          gt_q, gt_d;
  logic [CW-1:0] ncmp_q, ncmp_d;

  logic [7:0] byte_a, byte_b;
  logic       c_lt, c_eq, c_gt;

  // Flipping the sign bit of the top byte maps two's complement onto unsigned order.
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end
    if (sgn_q && (idx_q == IDX_TOP)) begin
      byte_a[7] = ~byte_a[7];
      byte_b[7] = ~byte_b[7];
    end
  end

  eight_bit_comparator u_cmp (
    .a     (byte_a),
    .b     (byte_b),
    .lt_in (1'b0),
    .eq_in (1'b1),
    .gt_in (1'b0),
    .lt    (c_lt),
    .eq    (c_eq),
    .gt    (c_gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    ncmp_d  = ncmp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_cmp;
          idx_d   = IDX_TOP;
          cnt_d   = '0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        cnt_d = cnt_q + CW'(1);
        if (!c_eq) begin
          lt_d    = c_lt;
          eq_d    = 1'b0;
          gt_d    = c_gt;
          ncmp_d  = cnt_q + CW'(1);
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          ncmp_d  = CW'(NBYTES);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= IDX_TOP;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      ncmp_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      ncmp_q  <= ncmp_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign ncmp = ncmp_q;

endmodule

// File: tb/tb_wide_comparator_sequencer.sv
// Directed and randomized checks of wide_comparator_sequencer at 1, 4 and 16 bytes.

module tb_wide_comparator_sequencer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start1, start4, start16;
  logic         sg;
  logic [127:0] a16, b16;

  logic       busy1, done1, lt1, eq1, gt1;
  logic [0:0] ncmp1;
  logic       busy4, done4, lt4, eq4, gt4;
  logic [2:0] ncmp4;
  logic       busy16, done16, lt16, eq16, gt16;
  logic [4:0] ncmp16;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2:0] prev_f;

  always #5 clk = ~clk;

  wide_comparator_sequencer u4 (
    .clk(clk), .rstn(rstn), .start(start4), .signed_cmp(sg),
    .a(a16[31:0]), .b(b16[31:0]), .busy(busy4), .done(done4),
    .lt(lt4), .eq(eq4), .gt(gt4), .ncmp(ncmp4)
  );

  wide_comparator_sequencer #(.NBYTES(1)) u1 (
    .clk(clk), .rstn(rstn), .start(start1), .signed_cmp(sg),
    .a(a16[7:0]), .b(b16[7:0]), .busy(busy1), .done(done1),
    .lt(lt1), .eq(eq1), .gt(gt1), .ncmp(ncmp1)
  );

  wide_comparator_sequencer #(.NBYTES(16)) u16 (
    .clk(clk), .rstn(rstn), .start(start16), .signed_cmp(sg),
    .a(a16), .b(b16), .busy(busy16), .done(done16),
    .lt(lt16), .eq(eq16), .gt(gt16), .ncmp(ncmp16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference compare on whole values; flags are {lt,eq,gt}.
  function automatic void ref_cmp(input logic [127:0] av, input logic [127:0] bv, input int n,
                                  input logic s, output logic [2:0] f, output int m);
    logic [127:0]        mask, ua, ub;
    logic signed [127:0] sa, sb;
    int lead;
    mask = (n == 16) ? '1 : ((128'd1 << (8 * n)) - 128'd1);
    ua = av & mask;
    ub = bv & mask;
    sa = ua << (128 - 8 * n);
    sb = ub << (128 - 8 * n);
    if (s) f = (sa < sb) ? 3'b100 : (sa > sb) ? 3'b001 : 3'b010;
    else   f = (ua < ub) ? 3'b100 : (ua > ub) ? 3'b001 : 3'b010;
    lead = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (ua[8*i +: 8] == ub[8*i +: 8]) lead++;
      else break;
    end
    m = (lead + 1 > n) ? n : lead + 1;
  endfunction

  task automatic run4(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic s, input logic [2:0] ef, input int m);
    int lat, bcnt;
    @(negedge clk);
    a16 = {96'h0, av};
    b16 = {96'h0, bv};
    sg = s;
    start4 = 1'b1;
    lat = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      lat++;
      if (busy4) bcnt++;
      if (lat == 1) check({tag, "_hold"}, 64'({lt4, eq4, gt4}), 64'(prev_f));
    end while (!done4 && lat < 40);
    check({tag, "_lat"}, 64'(lat), 64'(m + 1));
    check({tag, "_flags"}, 64'({lt4, eq4, gt4}), 64'(ef));
    check({tag, "_ncmp"}, 64'(ncmp4), 64'(m));
    @(negedge clk);
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(m + 1));
    check({tag, "_after"}, 64'({busy4, done4, lt4, eq4, gt4}), 64'({2'b00, ef}));
    prev_f = ef;
  endtask

  // Start-held pattern: byte (3 - k%4) is the first difference, so m = k%4 + 1.
  function automatic void mk(input int k, output logic [31:0] av, output logic [31:0] bv,
                             output logic [2:0] f, output int m);
    int j;
    logic [7:0] by;
    j = k % 4;
    av = {8'h10 + 8'(k), 8'h22, 8'h33, 8'h44};
    bv = av;
    by = av[8*(3-j) +: 8];
    bv[8*(3-j) +: 8] = (k % 2 == 1) ? by + 8'd1 : by - 8'd1;
    f = (k % 2 == 1) ? 3'b100 : 3'b001;
    m = j + 1;
  endfunction

  initial begin
    int done_at, next_acc, pend_m;
    logic [2:0] pend_f;
    rstn = 1'b0;
    start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    sg = 1'b0;
    a16 = '0; b16 = '0;
    prev_f = 3'b000;
    repeat (2) @(negedge clk);
    check("reset_u4", 64'({busy4, done4, lt4, eq4, gt4, ncmp4}), 64'd0);
    check("reset_u16", 64'({busy16, done16, lt16, eq16, gt16, ncmp16}), 64'd0);
    rstn = 1'b1;

    run4("eq_all",    32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b010, 4);
    run4("lt_b2",     32'h12345678, 32'h12355678, 1'b0, 3'b100, 2);
    run4("gt_b2",     32'h12355678, 32'h12345678, 1'b0, 3'b001, 2);
    run4("signed_lt", 32'h80000000, 32'h00000001, 1'b1, 3'b100, 1);
    run4("uns_gt",    32'h80000000, 32'h00000001, 1'b0, 3'b001, 1);
    run4("signed_gt", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 3'b001, 4);

    // start held high: accept at k, done seen at k+m+1, next accept at k+m+2
    done_at = -1;
    next_acc = 0;
    pend_f = 3'b000;
    pend_m = 0;
    sg = 1'b0;
    for (int k = 0; k < 30; k++) begin
      logic [31:0] av, bv;
      logic [2:0] f;
      int m;
      @(negedge clk);
      if (k > 0) check("held_done", 64'(done4), 64'(k == done_at));
      if (k == done_at) begin
        check("held_flags", 64'({lt4, eq4, gt4}), 64'(pend_f));
        check("held_ncmp", 64'(ncmp4), 64'(pend_m));
      end
      mk(k, av, bv, f, m);
      if (k == next_acc) begin
        pend_f = f;
        pend_m = m;
        done_at = k + m + 1;
        next_acc = k + m + 2;
      end
      a16 = {96'h0, av};
      b16 = {96'h0, bv};
      start4 = 1'b1;
    end
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    // reset while byte 2 is being compared
    a16 = {96'h0, 32'h11223344};
    b16 = {96'h0, 32'h11223345};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 64'(busy4), 64'd1);
    #2 rstn = 1'b0;
    #1 check("async_rst", 64'({busy4, done4, lt4, eq4, gt4, ncmp4}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", 64'(done4), 64'd0);
    end
    rstn = 1'b1;
    prev_f = 3'b000;
    run4("post_rst", 32'h11223344, 32'h11223345, 1'b0, 3'b100, 4);

    // randomized operations on all three widths at once
    for (int i = 0; i < 200; i++) begin
      logic [127:0] av, bv;
      logic [2:0] f1, f4, f16, e;
      int n1, n4, n16, em, cyc, j;
      logic s1, s4, s16;
      av = {$urandom, $urandom, $urandom, $urandom};
      bv = av;
      j = (i % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      if (i % 10 != 0) begin
        bv[8*j +: 8] = av[8*j +: 8] ^ 8'($urandom_range(1, 255));
        for (int q = 0; q < j; q++) bv[8*q +: 8] = 8'($urandom);
      end
      @(negedge clk);
      a16 = av;
      b16 = bv;
      sg = 1'($urandom);
      start1 = 1'b1; start4 = 1'b1; start16 = 1'b1;
      s1 = 0; s4 = 0; s16 = 0;
      f1 = '0; f4 = '0; f16 = '0;
      n1 = 0; n4 = 0; n16 = 0;
      cyc = 0;
      do begin
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
        cyc++;
        if (done1 && !s1)   begin s1 = 1;  f1 = {lt1, eq1, gt1};    n1 = int'(ncmp1);  end
        if (done4 && !s4)   begin s4 = 1;  f4 = {lt4, eq4, gt4};    n4 = int'(ncmp4);  end
        if (done16 && !s16) begin s16 = 1; f16 = {lt16, eq16, gt16}; n16 = int'(ncmp16); end
      end while (!(s1 && s4 && s16) && cyc < 30);
      check("rnd_done1", 64'(s1), 64'd1);
      check("rnd_done4", 64'(s4), 64'd1);
      check("rnd_done16", 64'(s16), 64'd1);
      ref_cmp(av, bv, 1, sg, e, em);
      check("rnd_flags1", 64'(f1), 64'(e));
      check("rnd_ncmp1", 64'(n1), 64'(em));
      ref_cmp(av, bv, 4, sg, e, em);
      check("rnd_flags4", 64'(f4), 64'(e));
      check("rnd_ncmp4", 64'(n4), 64'(em));
      ref_cmp(av, bv, 16, sg, e, em);
      check("rnd_flags16", 64'(f16), 64'(e));
      check("rnd_ncmp16", 64'(n16), 64'(em));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
